// File: rtl/e_mdu_ctrl_pkg.sv
// e_mdu_ctrl_pkg: op codes, FSM states and op-class helpers for the E-stage multiply/divide unit
package e_mdu_ctrl_pkg;
   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MTHI  = 4'd5,
      MD_MTLO  = 4'd6,
      MD_MFHI  = 4'd7,
      MD_MFLO  = 4'd8
   } md_op_e;

   typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

   function automatic logic is_div(input logic [3:0] op);
      return op == MD_DIV || op == MD_DIVU;
   endfunction

   function automatic logic is_muldiv(input logic [3:0] op);
      return op == MD_MULT || op == MD_MULTU || is_div(op);
   endfunction
endpackage

// File: rtl/e_mdu_ctrl_md_compute.sv
// e_mdu_ctrl_md_compute: combinational product/quotient/remainder for one MD op
module e_mdu_ctrl_md_compute
   import e_mdu_ctrl_pkg::*;
(
   input  logic [3:0]  i_md_op,
   input  logic [31:0] i_src_a,
   input  logic [31:0] i_src_b,
   output logic [31:0] o_p_hi,
   output logic [31:0] o_p_lo,
   output logic        o_div0
);
   logic signed [63:0] w_sprod;
   logic [63:0]        w_uprod;
   logic               w_sgn;
   logic [31:0]        w_a, w_b, w_q, w_r;

   // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
   always_comb begin
      w_sprod = 64'($signed(i_src_a)) * 64'($signed(i_src_b));
      w_uprod = {32'h0, i_src_a} * {32'h0, i_src_b};
      w_sgn   = i_md_op == MD_DIV;
      o_div0  = is_div(i_md_op) && i_src_b == 32'h0;
      w_a     = (w_sgn && i_src_a[31]) ? -i_src_a : i_src_a;
      w_b     = o_div0 ? 32'd1 : (w_sgn && i_src_b[31]) ? -i_src_b : i_src_b;
      w_q     = w_a / w_b;
      w_r     = w_a % w_b;
      {o_p_hi, o_p_lo} = (i_md_op == MD_MULT) ? w_sprod : w_uprod;
      if (is_div(i_md_op)) begin
         o_p_lo = (w_sgn && (i_src_a[31] ^ i_src_b[31])) ? -w_q : w_q;
         o_p_hi = (w_sgn && i_src_a[31]) ? -w_r : w_r;
      end
   end
endmodule

// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage MD sequencer; holds a computed result for a fixed latency, then commits HI/LO
module e_mdu_ctrl
   import e_mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  md_op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);
   md_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [31:0]      r_p_hi, r_p_lo, w_p_hi, w_p_lo;
   logic             r_div0, w_div0, w_load, w_commit, w_idle_start;

   e_mdu_ctrl_md_compute u_compute (
      .i_md_op (md_op),
      .i_src_a (srcA),
      .i_src_b (srcB),
      .o_p_hi  (w_p_hi),
      .o_p_lo  (w_p_lo),
      .o_div0  (w_div0)
   );

   assign busy         = r_state == MD_RUN;
   assign w_idle_start = start && r_state == MD_IDLE;
   assign md_rdata     = (md_op == MD_MFHI) ? hi : (md_op == MD_MFLO) ? lo : 32'h0;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      w_commit    = 1'b0;
      if (r_state == MD_IDLE) begin
         if (w_idle_start && is_muldiv(md_op)) begin
            w_state_nxt = MD_RUN;
            w_load      = 1'b1;
            w_cnt_nxt   = is_div(md_op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
         end
      end else if (r_cnt == '0) begin
         w_state_nxt = MD_IDLE;
         w_commit    = 1'b1;
      end else begin
         w_cnt_nxt = r_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p_hi <= 32'h0;
         r_p_lo <= 32'h0;
         r_div0 <= 1'b0;
      end else if (w_load) begin
         r_p_hi <= w_p_hi;
         r_p_lo <= w_p_lo;
         r_div0 <= w_div0;
      end
   end

   // Divide by zero still runs the full sequence but leaves HI/LO untouched at commit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi <= 32'h0;
         lo <= 32'h0;
      end else if (w_commit && !r_div0) begin
         hi <= r_p_hi;
         lo <= r_p_lo;
      end else if (w_idle_start && md_op == MD_MTHI) begin
         hi <= srcA;
      end else if (w_idle_start && md_op == MD_MTLO) begin
         lo <= srcA;
      end
   end
endmodule

// File: tb/tb_e_mdu_ctrl.sv
// tb_e_mdu_ctrl: table-driven MD ops with a commit scoreboard, plus hand-written corner sequences
module tb_e_mdu_ctrl;
   import e_mdu_ctrl_pkg::*;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0;
   logic [3:0]  md_op = 4'd0;
   logic [31:0] srcA = 32'h0, srcB = 32'h0;
   logic        busy;
   logic [31:0] hi, lo, md_rdata;
   int          checks = 0, failures = 0;

   typedef struct {logic [31:0] hi; logic [31:0] lo; int n;} exp_t;
   typedef struct {logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] ehi; logic [31:0] elo; int n;} vec_t;

   exp_t sb[$];
   vec_t vt[10];

   e_mdu_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .md_op    (md_op),
      .srcA     (srcA),
      .srcB     (srcB),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .md_rdata (md_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      md_op = op;
      srcA  = a;
      srcB  = b;
      @(negedge clk);
      start = 1'b0;
      md_op = MD_NONE;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      drive(op, a, b);
   endtask

   // Count busy cycles (c0 already seen), then pop and compare the committed result
   task automatic wait_commit(input string nm, input int c0);
      exp_t e;
      int   cyc = c0;
      while (busy && cyc < 40) begin
         cyc++;
         @(negedge clk);
      end
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s_sb: got empty scoreboard expected one entry", nm);
      end else begin
         e = sb.pop_front();
         chk({nm, "_cycles"}, 32'(cyc), 32'(e.n));
         chk({nm, "_hi"}, hi, e.hi);
         chk({nm, "_lo"}, lo, e.lo);
      end
   endtask

   initial begin
      vt[0] = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};
      vt[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vt[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vt[3] = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vt[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vt[5] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vt[6] = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10};
      vt[7] = '{MD_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 5};
      vt[8] = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
      vt[9] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};

      #1;
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         issue(vt[i].op, vt[i].a, vt[i].b);
         sb.push_back('{vt[i].ehi, vt[i].elo, vt[i].n});
         wait_commit($sformatf("vec%0d", i), 0);
      end

      // mthi/mtlo while idle: visible at the next edge, no busy
      issue(MD_MTHI, 32'h12345678, 32'h0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'h0, busy}, 32'h0);
      issue(MD_MTLO, 32'hCAFEF00D, 32'h0);
      chk("mtlo_lo", lo, 32'hCAFEF00D);
      md_op = MD_MFHI;
      #1 chk("mfhi_rdata", md_rdata, 32'h12345678);
      md_op = MD_NONE;
      #1 chk("none_rdata", md_rdata, 32'h0);

      // mtlo during a busy div is dropped
      issue(MD_DIV, 32'h00000064, 32'h00000007);
      sb.push_back('{32'h00000002, 32'h0000000E, 10});
      drive(MD_MTLO, 32'hDEADBEEF, 32'h0);
      chk("mtlo_busy_lo", lo, 32'hCAFEF00D);
      wait_commit("div_mtlo", 1);

      // mflo the cycle after busy falls, then back-to-back start on that cycle
      issue(MD_MULT, 32'h00000006, 32'h00000007);
      sb.push_back('{32'h00000000, 32'h0000002A, 5});
      wait_commit("mult_a", 0);
      md_op = MD_MFLO;
      #1 chk("mflo_rdata", md_rdata, 32'h0000002A);
      drive(MD_MULTU, 32'h00000003, 32'h00000009);
      sb.push_back('{32'h00000000, 32'h0000001B, 5});
      chk("b2b_busy", {31'h0, busy}, 32'h1);
      wait_commit("mult_b", 0);

      // async reset in the third busy cycle discards the in-flight mult
      issue(MD_MULT, 32'h00000003, 32'h00000005);
      @(negedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_busy", {31'h0, busy}, 32'h0);
      chk("midrst_hi", hi, 32'h0);
      chk("midrst_lo", lo, 32'h0);
      #1 reset_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("postrst_busy", {31'h0, busy}, 32'h0);
      chk("postrst_hi", hi, 32'h0);
      chk("postrst_lo", lo, 32'h0);
      chk("sb_empty", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
